// File: rtl/collatz_sweep.sv
// Sweep driver around a collatz stage: issues start..start+count-1, returns the input with the most steps.
// Latency: first issue one cycle after command fire; result one cycle after the last step count retires.
// Backpressure: stage in_ready stalls issue, a full tag FIFO stalls issue only, out_ready=0 holds the result.

module collatz_sweep_tag_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign pop_dat = mem_q[rd_q];
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);

  // Pointer/occupancy update; a simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module collatz_sweep #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_start,
  input  logic [N-1:0] in_count,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_best_n,
  output logic [N-1:0] out_best_steps,
  output logic         dut_in_valid,
  input  logic         dut_in_ready,
  output logic [N-1:0] dut_in0,
  input  logic         dut_out_valid,
  output logic         dut_out_ready,
  input  logic [N-1:0] dut_out0
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] start_q, start_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] issue_q, issue_d;
  logic [N-1:0] retire_q, retire_d;
  logic [N-1:0] best_n_q, best_n_d;
  logic [N-1:0] best_steps_q, best_steps_d;

  logic         issue_fire;
  logic         retire_fire;
  logic [N-1:0] tag_head;
  logic         tag_full;
  logic         tag_empty;

  // Wraps modulo 2^N; the caller keeps zero out of the sweep.
  assign dut_in0        = start_q + issue_q;
  assign out_best_n     = best_n_q;
  assign out_best_steps = best_steps_q;

  // Handshake outputs, derived from registered state only.
  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    dut_in_valid  = 1'b0;
    dut_out_ready = 1'b0;
    case (state_q)
      IDLE:  in_ready = 1'b1;
      RUN: begin
        dut_in_valid  = !tag_full;
        dut_out_ready = !tag_empty;
      end
      DRAIN: dut_out_ready = !tag_empty;
      DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign issue_fire  = dut_in_valid && dut_in_ready;
  assign retire_fire = dut_out_valid && dut_out_ready;

  // Tags travel alongside the in-order stage so each step count meets its input.
  collatz_sweep_tag_fifo #(.W(N), .DEPTH(DEPTH)) u_tag_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (issue_fire),
    .push_dat (dut_in0),
    .pop      (retire_fire),
    .pop_dat  (tag_head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // Next-state: command latch, issue/retire counting, running maximum and state transitions.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    count_d      = count_q;
    issue_d      = issue_q;
    retire_d     = retire_q;
    best_n_d     = best_n_q;
    best_steps_d = best_steps_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          start_d      = in_start;
          count_d      = in_count;
          issue_d      = '0;
          retire_d     = '0;
          best_n_d     = '0;
          best_steps_d = '0;
          state_d      = (in_count == '0) ? DONE : RUN;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (issue_fire) begin
      issue_d = issue_q + 1'b1;
      if (issue_d == count_q) state_d = DRAIN;
    end

    if (retire_fire) begin
      retire_d = retire_q + 1'b1;
      // Strict compare: on a tie the earlier input stays the winner.
      if (dut_out0 > best_steps_q) begin
        best_steps_d = dut_out0;
        best_n_d     = tag_head;
      end
      if (state_q == DRAIN && retire_d == count_q) state_d = DONE;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      start_q      <= '0;
      count_q      <= '0;
      issue_q      <= '0;
      retire_q     <= '0;
      best_n_q     <= '0;
      best_steps_q <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      count_q      <= count_d;
      issue_q      <= issue_d;
      retire_q     <= retire_d;
      best_n_q     <= best_n_d;
      best_steps_q <= best_steps_d;
    end
  end
endmodule
